// File: rtl/ahb_qspi_flash_reader.sv
// AHB-Lite read-only slave fetching 32-bit words from SST26-class QSPI flash with Quad I/O Fast Read (0xEB).
// Define FLASH_READER_CACHE_EN to add a one-entry prefetch buffer with zero-wait hits.
module ahb_qspi_flash_reader #(
    parameter logic [7:0] CMD       = 8'hEB,
    parameter logic [7:0] MODE_BYTE = 8'hFF,
    parameter int         DUMMY_SCK = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic        cache_inv,
    output logic        fr_sck,
    output logic        fr_ce_n,
    output logic [3:0]  fr_dout,
    output logic        fr_douten,
    input  logic [3:0]  fr_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sck_q, sck_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] hrdata_q, hrdata_d;

    logic        accept;
    logic        rd_req;
    logic        wr_req;
    logic        cache_hit;
    logic [31:0] cache_word;
    logic        load_cache;
    logic [2:0]  last_cnt;
    logic [31:0] fetched_word;
    logic [7:0]  cmd_sh;
    logic [23:0] addr_sh;
    logic [7:0]  mode_sh;

    // Requests are only taken when no fetch is in flight; HREADYOUT=0 holds the bus otherwise.
    assign accept = (state_q == S_IDLE) || (state_q == S_DONE);
    assign rd_req = accept & HSEL & HTRANS[1] & HREADY & ~HWRITE;
    assign wr_req = accept & HSEL & HTRANS[1] & HREADY & HWRITE;

    always_comb begin
        last_cnt = 3'd0;
        case (state_q)
            S_CMD:   last_cnt = 3'd7;
            S_ADDR:  last_cnt = 3'd5;
            S_MODE:  last_cnt = 3'd1;
            S_DUMMY: last_cnt = 3'(DUMMY_SCK - 1);
            S_DATA:  last_cnt = 3'd7;
            default: last_cnt = 3'd0;
        endcase
    end

    // Nibble 0 arrives first and is the high nibble of byte 0; bytes are placed little-endian.
    assign fetched_word = {shift_q[27:0], fr_din};

    always_comb begin
        state_d    = state_q;
        sck_d      = 1'b0;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        hrdata_d   = hrdata_q;
        load_cache = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (rd_req) begin
                    if (cache_hit) begin
                        hrdata_d = cache_word;
                    end else begin
                        state_d = S_START;
                        addr_d  = {HADDR[23:2], 2'b00};
                    end
                end else if (wr_req) begin
                    hrdata_d = 32'h0;
                end
            end
            S_START: begin
                state_d = S_CMD;
                cnt_d   = 3'd0;
            end
            S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (state_q == S_DATA) begin
                        shift_d = fetched_word;
                    end
                    if (cnt_q == last_cnt) begin
                        cnt_d = 3'd0;
                        case (state_q)
                            S_CMD:   state_d = S_ADDR;
                            S_ADDR:  state_d = S_MODE;
                            S_MODE:  state_d = S_DUMMY;
                            S_DUMMY: state_d = S_DATA;
                            default: begin
                                state_d    = S_DONE;
                                hrdata_d   = {fetched_word[7:0], fetched_word[15:8],
                                              fetched_word[23:16], fetched_word[31:24]};
                                load_cache = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            sck_q    <= 1'b0;
            cnt_q    <= 3'd0;
            addr_q   <= 24'h0;
            shift_q  <= 32'h0;
            hrdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            sck_q    <= sck_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign cmd_sh  = CMD << cnt_q;
    assign addr_sh = addr_q << {cnt_q, 2'b00};
    assign mode_sh = MODE_BYTE << {cnt_q[0], 2'b00};

    // IO3/IO2 idle high during the single-line command so HOLD#/WP# stay inactive.
    always_comb begin
        fr_dout   = 4'hF;
        fr_douten = 1'b0;
        case (state_q)
            S_START: begin
                fr_dout   = {3'b110, CMD[7]};
                fr_douten = 1'b1;
            end
            S_CMD: begin
                fr_dout   = {3'b110, cmd_sh[7]};
                fr_douten = 1'b1;
            end
            S_ADDR: begin
                fr_dout   = addr_sh[23:20];
                fr_douten = 1'b1;
            end
            S_MODE: begin
                fr_dout   = mode_sh[7:4];
                fr_douten = 1'b1;
            end
            default: begin
                fr_dout   = 4'hF;
                fr_douten = 1'b0;
            end
        endcase
    end

    assign HREADYOUT = accept;
    assign fr_ce_n   = accept;
    assign fr_sck    = sck_q;
    assign HRDATA    = hrdata_q;

`ifdef FLASH_READER_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [21:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic        unused_ok;

    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (load_cache) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = addr_q[23:2];
            cache_data_d  = hrdata_d;
        end
        if (cache_inv) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 22'h0;
            cache_data_q  <= 32'h0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end

    assign cache_hit  = cache_valid_q && (cache_tag_q == HADDR[23:2]);
    assign cache_word = cache_data_q;
    assign unused_ok  = ^{HADDR[31:24], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};
`else
    logic unused_ok;

    assign cache_hit  = 1'b0;
    assign cache_word = 32'h0;
    assign unused_ok  = ^{HADDR[31:24], HADDR[1:0], HTRANS[0], HSIZE, HWDATA,
                          cache_inv, load_cache};
`endif

endmodule

// File: tb/tb_ahb_qspi_flash_reader.sv
// Directed bench for ahb_qspi_flash_reader with a behavioural SST26 quad-read flash model.
// Cache scenarios are compiled in when FLASH_READER_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_ahb_qspi_flash_reader;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    wire         HREADY;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = 32'h0;
    wire         HREADYOUT;
    wire  [31:0] HRDATA;
    logic        cache_inv = 1'b0;
    wire         fr_sck;
    wire         fr_ce_n;
    wire  [3:0]  fr_dout;
    wire         fr_douten;
    logic [3:0]  fr_din = 4'h0;

    int checks = 0;
    int errors = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_qspi_flash_reader dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .cache_inv (cache_inv),
        .fr_sck    (fr_sck),
        .fr_ce_n   (fr_ce_n),
        .fr_dout   (fr_dout),
        .fr_douten (fr_douten),
        .fr_din    (fr_din)
    );

    // Flash model: decodes command/address/mode on SCK rise, drives data after the 20th SCK fall.
    logic [7:0]  mem [0:511];
    int          sck_cnt = 0;
    int          sck_rises_total = 0;
    int          ce_falls_total = 0;
    int          oe_bad = 0;
    logic [7:0]  cmd_rx = 8'h0;
    logic [23:0] addr_rx = 24'h0;
    logic [7:0]  mode_rx = 8'h0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        mem[4] = 8'h05; mem[5] = 8'h16; mem[6] = 8'h27; mem[7] = 8'h38;
        mem[9'h104] = 8'h11; mem[9'h105] = 8'h22; mem[9'h106] = 8'h33; mem[9'h107] = 8'h44;
    end

    always @(negedge fr_ce_n or posedge fr_sck) begin
        if (fr_sck) begin
            if (sck_cnt < 8) begin
                cmd_rx = {cmd_rx[6:0], fr_dout[0]};
                if (!fr_douten || fr_dout[3:1] != 3'b110) oe_bad++;
            end else if (sck_cnt < 14) begin
                addr_rx = {addr_rx[19:0], fr_dout};
                if (!fr_douten) oe_bad++;
            end else if (sck_cnt < 16) begin
                mode_rx = {mode_rx[3:0], fr_dout};
                if (!fr_douten) oe_bad++;
            end else begin
                if (fr_douten) oe_bad++;
            end
            sck_cnt++;
            sck_rises_total++;
        end else begin
            sck_cnt = 0;
            cmd_rx  = 8'h0;
            addr_rx = 24'h0;
            mode_rx = 8'h0;
            oe_bad  = 0;
            ce_falls_total++;
        end
    end

    always @(negedge fr_sck) begin
        if (!fr_ce_n && sck_cnt >= 20 && sck_cnt < 28) begin
            int k;
            int a;
            logic [7:0] b;
            k = sck_cnt - 20;
            a = (int'(addr_rx) + k / 2) & 511;
            b = mem[a];
            #1;
            fr_din = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Bus driver: one read transfer, returns data and number of wait states (9999 on timeout).
    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
        bit got;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        waits = 0;
        got = 1'b0;
        data = 32'h0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                data = HRDATA;
                got = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!got) waits = 9999;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge HCLK);
            checks += 4;
            if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout cyc%0d got %b exp 1", c, HREADYOUT); end
            if (fr_ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n cyc%0d got %b exp 1", c, fr_ce_n); end
            if (fr_sck !== 1'b0) begin errors++; $display("FAIL reset_sck cyc%0d got %b exp 0", c, fr_sck); end
            if (fr_douten !== 1'b0) begin errors++; $display("FAIL reset_douten cyc%0d got %b exp 0", c, fr_douten); end
        end
        checks += 2;
        if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h exp 00000000", HRDATA); end
        if (fr_dout !== 4'hF) begin errors++; $display("FAIL reset_dout got %h exp f", fr_dout); end
        $display("test_reset: done");
    endtask

    task automatic test_single_read;
        logic [31:0] d;
        int w;
        ahb_read(32'h0000_0104, d, w);
        checks += 7;
        if (w !== 57) begin errors++; $display("FAIL read_waits got %0d exp 57", w); end
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL read_data got %h exp 44332211", d); end
        if (cmd_rx !== 8'hEB) begin errors++; $display("FAIL read_cmd got %h exp eb", cmd_rx); end
        if (addr_rx !== 24'h000104) begin errors++; $display("FAIL read_addr got %h exp 000104", addr_rx); end
        if (mode_rx !== 8'hFF) begin errors++; $display("FAIL read_mode got %h exp ff", mode_rx); end
        if (oe_bad !== 0) begin errors++; $display("FAIL read_douten got %0d bad sck exp 0", oe_bad); end
        if (sck_cnt !== 28) begin errors++; $display("FAIL read_sck_count got %0d exp 28", sck_cnt); end
        @(negedge HCLK);
        checks++;
        if (fr_ce_n !== 1'b1) begin errors++; $display("FAIL read_ce_after got %b exp 1", fr_ce_n); end
        $display("read 0x104: data=%h waits=%0d", d, w);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d0, d1;
        int w0, w1;
        bit got;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HADDR = 32'h4;
        w0 = 0; got = 1'b0; d0 = 32'h0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin d0 = HRDATA; got = 1'b1; end else w0++;
        end
        checks++;
        if (fr_ce_n !== 1'b1) begin errors++; $display("FAIL b2b_ce_gap_high got %b exp 1", fr_ce_n); end
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        checks++;
        if (fr_ce_n !== 1'b0) begin errors++; $display("FAIL b2b_ce_gap_len got ce_n=%b exp 0 after 1 cycle", fr_ce_n); end
        w1 = 1; got = 1'b0; d1 = 32'h0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin d1 = HRDATA; got = 1'b1; end else w1++;
        end
        checks += 5;
        if (w0 !== 57) begin errors++; $display("FAIL b2b_waits0 got %0d exp 57", w0); end
        if (d0 !== 32'hD4C3_B2A1) begin errors++; $display("FAIL b2b_data0 got %h exp d4c3b2a1", d0); end
        if (w1 !== 57) begin errors++; $display("FAIL b2b_waits1 got %0d exp 57", w1); end
        if (d1 !== 32'h3827_1605) begin errors++; $display("FAIL b2b_data1 got %h exp 38271605", d1); end
        if (addr_rx !== 24'h000004) begin errors++; $display("FAIL b2b_addr1 got %h exp 000004", addr_rx); end
        $display("back_to_back: d0=%h w0=%0d d1=%h w1=%0d", d0, w0, d1, w1);
    endtask

    task automatic test_write;
        int sck0, ce0;
        sck0 = sck_rises_total;
        ce0 = ce_falls_total;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        checks += 2;
        if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL write_hreadyout got %b exp 1", HREADYOUT); end
        if (HRDATA !== 32'h0) begin errors++; $display("FAIL write_hrdata got %h exp 00000000", HRDATA); end
        for (int c = 0; c < 5; c++) begin
            @(negedge HCLK);
            checks++;
            if (fr_ce_n !== 1'b1) begin errors++; $display("FAIL write_ce cyc%0d got %b exp 1", c, fr_ce_n); end
        end
        checks += 2;
        if (sck_rises_total !== sck0) begin errors++; $display("FAIL write_sck_edges got %0d exp %0d", sck_rises_total, sck0); end
        if (ce_falls_total !== ce0) begin errors++; $display("FAIL write_ce_falls got %0d exp %0d", ce_falls_total, ce0); end
        $display("write 0x10: hrdata=%h", HRDATA);
    endtask

    task automatic test_reset_mid_fetch;
        int target;
        bit reached;
        logic [31:0] d;
        int w;
        target = sck_rises_total + 10;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h104;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge HCLK);
            if (sck_rises_total >= target) reached = 1'b1;
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL rmf_sck10_timeout got %0d rises exp %0d", sck_rises_total, target); end
        #2;
        HRESETn = 1'b0;
        #1;
        checks += 3;
        if (fr_ce_n !== 1'b1) begin errors++; $display("FAIL rmf_ce_n got %b exp 1", fr_ce_n); end
        if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rmf_hreadyout got %b exp 1", HREADYOUT); end
        if (fr_sck !== 1'b0) begin errors++; $display("FAIL rmf_sck got %b exp 0", fr_sck); end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_read(32'h104, d, w);
        checks += 2;
        if (w !== 57) begin errors++; $display("FAIL rmf_reread_waits got %0d exp 57", w); end
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL rmf_reread_data got %h exp 44332211", d); end
        $display("reset_mid_fetch: reread data=%h waits=%0d", d, w);
    endtask

`ifdef FLASH_READER_CACHE_EN
    task automatic test_cache;
        logic [31:0] d;
        int w, ce0;
        ce0 = ce_falls_total;
        ahb_read(32'h104, d, w);
        checks += 3;
        if (w !== 0) begin errors++; $display("FAIL cache_hit_waits got %0d exp 0", w); end
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL cache_hit_data got %h exp 44332211", d); end
        if (ce_falls_total !== ce0) begin errors++; $display("FAIL cache_hit_ce got %0d falls exp %0d", ce_falls_total, ce0); end
        $display("cache hit 0x104: data=%h waits=%0d", d, w);
        @(posedge HCLK); #1;
        cache_inv = 1'b1;
        @(posedge HCLK); #1;
        cache_inv = 1'b0;
        ahb_read(32'h104, d, w);
        checks += 3;
        if (w !== 57) begin errors++; $display("FAIL cache_inv_waits got %0d exp 57", w); end
        if (d !== 32'h4433_2211) begin errors++; $display("FAIL cache_inv_data got %h exp 44332211", d); end
        if (ce_falls_total !== ce0 + 1) begin errors++; $display("FAIL cache_inv_ce got %0d falls exp %0d", ce_falls_total, ce0 + 1); end
        $display("cache after inv 0x104: data=%h waits=%0d", d, w);
    endtask
`endif

    initial begin
        test_reset;
        test_single_read;
        test_back_to_back;
        test_write;
        test_reset_mid_fetch;
`ifdef FLASH_READER_CACHE_EN
        test_cache;
`endif
        repeat (3) @(negedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
